fp_decode: RTL and testbench

Sequential decoder that turns the 9-bit floating-point code (sign S, 3-bit exponent E, 5-bit significand F) back into a 13-bit two's-complement integer D = (−1)^S · F · 2^E. It is the inverse-direction companion of the team's integer-to-float converter and sits on the downstream side of a stored or transmitted FP code. It uses a one-bit-per-cycle shifter with valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_sign_apply.sv | 23 ++
 rtl/fp_decode.sv | 100 ++++++++++
 tb/tb_fp_decode.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared widths and state encoding for the 9-bit FP code format.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int D_W = 13;
    localparam int E_W = 3;
    localparam int F_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_sign_apply.sv
// ============================================================================
// Module  : fp_sign_apply
// Brief   : Combinational conditional two's-complement negate of a magnitude.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_sign_apply
    import fp_pkg::*;
(
    input  logic           sign,
    input  logic [D_W-1:0] mag,
    output logic [D_W-1:0] value
);

    // A zero magnitude negates back to zero, so -0 can never appear.
    always_comb begin
        value = sign ? (~mag + {{(D_W-1){1'b0}}, 1'b1}) : mag;
    end

endmodule

`default_nettype wire

// File: rtl/fp_decode.sv
// ============================================================================
// Module  : fp_decode
// Brief   : Sequential FP-code to integer decoder, one left shift per cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_decode
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           S,
    input  logic [E_W-1:0] E,
    input  logic [F_W-1:0] F,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] D
);

    state_t         state_q, state_d;
    logic           s_q, s_d;
    logic [E_W-1:0] cnt_q, cnt_d;
    logic [D_W-1:0] mag_q, mag_d;
    logic [D_W-1:0] d_q, d_d;
    logic           out_valid_q, out_valid_d;
    logic [D_W-1:0] signed_val;

    fp_sign_apply u_sign_apply (
        .sign  (s_q),
        .mag   (mag_q),
        .value (signed_val)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = S;
                    cnt_d   = E;
                    mag_d   = {{(D_W-F_W){1'b0}}, F};
                    state_d = (E == '0) ? SIGN : SHIFT;
                end
            end
            SHIFT: begin
                mag_d = mag_q << 1;
                cnt_d = cnt_q - {{(E_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(E_W-1){1'b0}}, 1'b1}) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                d_d         = signed_val;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            cnt_q       <= '0;
            mag_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Handshake outputs come straight from flops; no input reaches them combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign D         = d_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_decode.sv
// ============================================================================
// Module  : tb_fp_decode
// Brief   : Directed self-checking bench for fp_decode.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_decode;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [4:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] D;

    int total;
    int bad;

    fp_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a code once in_ready is seen; returns with in_valid dropped after the edge.
    task automatic send(input logic s, input logic [2:0] e, input logic [4:0] f);
        int guard;
        guard = 0;
        while (!in_ready && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        S = s; E = e; F = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid; 99 means it never came.
    task automatic wait_result(output int lat, output bit ir_low);
        bit seen;
        seen   = 1'b0;
        ir_low = 1'b1;
        lat    = 99;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (in_ready) ir_low = 1'b0;
            @(posedge clk); #1;
            if (out_valid) begin
                lat  = k;
                seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (D !== 13'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: D=%h out_valid=%b in_ready=%b, required D=0000 out_valid=0 in_ready=1",
                     D, out_valid, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_e0;
        int lat; bit irl;
        out_ready = 1'b1;
        send(1'b0, 3'd0, 5'd5);
        wait_result(lat, irl);
        total++;
        if (lat !== 1 || D !== 13'h0005) begin
            bad++;
            $display("FAIL e0: lat=%0d D=%h, required lat=1 D=0005", lat, D);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL e0_handoff: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_e7;
        int lat; bit irl;
        send(1'b0, 3'd7, 5'd31);
        wait_result(lat, irl);
        total++;
        if (lat !== 8 || D !== 13'h0F80) begin
            bad++;
            $display("FAIL e7: lat=%0d D=%h, required lat=8 D=0f80", lat, D);
        end
        total++;
        if (irl !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL e7_in_ready: stayed_low=%b now=%b, required 1 and 0", irl, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_negative;
        int lat; bit irl;
        send(1'b1, 3'd3, 5'd20);
        wait_result(lat, irl);
        total++;
        if (lat !== 4 || D !== 13'h1F60) begin
            bad++;
            $display("FAIL neg: lat=%0d D=%h, required lat=4 D=1f60", lat, D);
        end
        @(posedge clk); #1;
        send(1'b0, 3'd2, 5'd3);
        wait_result(lat, irl);
        total++;
        if (lat !== 3 || D !== 13'h000C) begin
            bad++;
            $display("FAIL nonnorm: lat=%0d D=%h, required lat=3 D=000c", lat, D);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_neg_zero;
        int lat; bit irl;
        send(1'b1, 3'd5, 5'd0);
        wait_result(lat, irl);
        total++;
        if (lat !== 6 || D !== 13'h0000) begin
            bad++;
            $display("FAIL neg_zero: lat=%0d D=%h, required lat=6 D=0000", lat, D);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat; bit irl;
        out_ready = 1'b0;
        send(1'b0, 3'd2, 5'd7);
        wait_result(lat, irl);
        total++;
        if (lat !== 3 || D !== 13'h001C) begin
            bad++;
            $display("FAIL bp_result: lat=%0d D=%h, required lat=3 D=001c", lat, D);
        end
        S = 1'b1; E = 3'd0; F = 5'd9;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (D !== 13'h001C || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: D=%h out_valid=%b in_ready=%b, required 001c 1 0",
                         c, D, out_valid, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 13'h001C) begin
            bad++;
            $display("FAIL bp_ignored: out_valid=%b in_ready=%b D=%h, required 0 1 001c",
                     out_valid, in_ready, D);
        end
    endtask

    task automatic test_reset_mid_shift;
        int lat; bit irl; bit leaked;
        out_ready = 1'b1;
        send(1'b0, 3'd6, 5'd9);
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 13'h0000) begin
            bad++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b D=%h, required 0 1 0000",
                     out_valid, in_ready, D);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        leaked = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) leaked = 1'b1;
        end
        total++;
        if (leaked !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_result: out_valid_seen=%b, required 0", leaked);
        end
        send(1'b0, 3'd1, 5'd16);
        wait_result(lat, irl);
        total++;
        if (lat !== 2 || D !== 13'h0020) begin
            bad++;
            $display("FAIL rst_fresh: lat=%0d D=%h, required lat=2 D=0020", lat, D);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        S         = 1'b0;
        E         = '0;
        F         = '0;
        rst_n     = 1'b1;
        #2;
        test_reset;
        test_e0;
        test_e7;
        test_negative;
        test_neg_zero;
        test_backpressure;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
